// File: rtl/imem_pkg.sv
// Shared sizing constants and FSM state encoding for the instruction-memory loader.
package imem_pkg;

    localparam int unsigned DEPTH   = 64;
    localparam int unsigned ADDR_W  = 6;
    // Width of the word_count input and of the stored target count.
    localparam int unsigned COUNT_W = 7;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/byte_assembler.sv
// Collects four little-endian bytes into one 32-bit instruction word.
// 'assembled' is the word as it would read if the byte on byte_data were taken
// now, so the loader can register a complete word on the cycle of the fourth byte.
module byte_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        take,
    input  logic [7:0]  byte_data,
    output logic [31:0] assembled,
    output logic        last
);

    logic [1:0]  idx_q;
    logic [31:0] word_q;

    // Byte index and partial word; the index wraps to 0 after the fourth byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= 2'd0;
            word_q <= 32'd0;
        end else if (clear) begin
            idx_q  <= 2'd0;
            word_q <= 32'd0;
        end else if (take) begin
            word_q[{idx_q, 3'b000} +: 8] <= byte_data;
            idx_q                        <= idx_q + 2'd1;
        end
    end

    // Merge the offered byte into its lane of the partial word.
    always_comb begin
        assembled                       = word_q;
        assembled[{idx_q, 3'b000} +: 8] = byte_data;
    end

    assign last = (idx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams a byte-wide program image into instruction memory while holding the CPU busy.
module imem_loader #(
    parameter int unsigned DEPTH  = imem_pkg::DEPTH,
    parameter int unsigned ADDR_W = imem_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [6:0]        word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    import imem_pkg::*;

    localparam logic [COUNT_W-1:0] DEPTH_C = COUNT_W'(DEPTH);

    state_t              state;
    logic [COUNT_W-1:0]  count_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         asm_word;
    logic                asm_last;
    logic                asm_clear;
    logic                xfer;
    logic                last_addr;

    // byte_ready is registered and only high in RECV, so it alone qualifies a transfer.
    assign xfer      = byte_valid && byte_ready;
    assign asm_clear = (state == IDLE) && start;
    assign last_addr = (COUNT_W'(addr_q) == (count_q - COUNT_W'(1)));

    byte_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (asm_clear),
        .take      (xfer),
        .byte_data (byte_data),
        .assembled (asm_word),
        .last      (asm_last)
    );

    // Load sequencer with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count_q    <= '0;
            addr_q     <= '0;
            byte_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        addr_q <= '0;
                        if (word_count > DEPTH_C) begin
                            count_q <= DEPTH_C;
                            err     <= 1'b1;
                        end else begin
                            count_q <= word_count;
                            err     <= 1'b0;
                        end
                        if (word_count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= RECV;
                            byte_ready <= 1'b1;
                            busy       <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (start) begin
                        err <= 1'b1;
                    end
                    if (xfer && asm_last) begin
                        state      <= WRITE;
                        byte_ready <= 1'b0;
                        wr_en      <= 1'b1;
                        wr_addr    <= addr_q;
                        wr_data    <= asm_word;
                    end
                end
                WRITE: begin
                    if (start) begin
                        err <= 1'b1;
                    end
                    if (last_addr) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        addr_q     <= addr_q + ADDR_W'(1);
                        state      <= RECV;
                        byte_ready <= 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        err <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  word_count = 7'd0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_ready;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int xfer_cnt = 0;
    int busy_seen = 0;
    int last_wr_cyc = 0;
    int last_done_cyc = 0;
    int last_wr_addr = 0;

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: note whether a byte transfers at this edge, then sample #1 after it.
    task automatic tick(output int xfer);
        wr_t e;
        xfer = (byte_valid === 1'b1 && byte_ready === 1'b1) ? 1 : 0;
        @(posedge clk);
        #1;
        cyc++;
        if (xfer != 0) xfer_cnt++;
        if (busy === 1'b1) busy_seen = 1;
        if (done === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (wr_en === 1'b1) begin
            wr_cnt++;
            last_wr_cyc  = cyc;
            last_wr_addr = int'(wr_addr);
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_write observed addr %h data %h expected none",
                       wr_addr, wr_data);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(wr_addr), e.addr);
                chk("wr_data", wr_data, e.data);
            end
        end
    endtask

    task automatic step();
        int x;
        tick(x);
    endtask

    task automatic do_start(input int wc);
        start      = 1'b1;
        word_count = 7'(wc);
        step();
        start      = 1'b0;
    endtask

    // Offer one byte with valid high until it is accepted (bounded).
    task automatic send_byte(input logic [7:0] b);
        int x;
        int took;
        took       = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 20; i++) begin
            tick(x);
            if (x != 0) begin
                took = 1;
                break;
            end
        end
        chk("byte_accepted", 32'(took), 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic wait_done(input int budget);
        int got;
        got = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (done === 1'b1) begin
                got = 1;
                break;
            end
        end
        chk("done_seen", 32'(got), 32'd1);
    endtask

    task automatic push_wr(input int addr, input logic [31:0] data);
        wr_t e;
        e.addr = 32'(addr);
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_wr_en"},      32'(wr_en),      32'd0);
        chk({tag, "_wr_addr"},    32'(wr_addr),    32'd0);
        chk({tag, "_wr_data"},    wr_data,         32'd0);
        chk({tag, "_busy"},       32'(busy),       32'd0);
        chk({tag, "_done"},       32'(done),       32'd0);
        chk({tag, "_err"},        32'(err),        32'd0);
    endtask

    function automatic logic [7:0] pat_byte(input int i, input int k);
        return 8'(i * 4 + k) ^ 8'h3C;
    endfunction

    initial begin
        int wr0;
        int done0;
        logic [6:0]  vpat;
        logic [31:0] w;

        // Reset state.
        #12;
        check_reset_outputs("rst");
        step();
        rst = 1'b0;
        step();
        check_reset_outputs("idle");

        // Two-word load with valid held high.
        push_wr(0, 32'h0000_0083);
        push_wr(1, 32'h0010_0103);
        wr0 = wr_cnt;
        do_start(2);
        chk("two_busy", 32'(busy), 32'd1);
        chk("two_ready", 32'(byte_ready), 32'd1);
        send_byte(8'h83); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h03); send_byte(8'h01); send_byte(8'h10); send_byte(8'h00);
        byte_valid = 1'b0;
        wait_done(10);
        chk("two_writes", 32'(wr_cnt - wr0), 32'd2);
        chk("two_done_lat", 32'(last_done_cyc), 32'(last_wr_cyc + 1));
        chk("two_busy_at_done", 32'(busy), 32'd0);
        chk("two_err", 32'(err), 32'd0);
        step();
        chk("two_idle_ready", 32'(byte_ready), 32'd0);

        // Zero-length load.
        wr0 = wr_cnt;
        busy_seen = 0;
        do_start(0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        step();
        step();
        chk("zero_done_pulse", 32'(done), 32'd0);
        chk("zero_writes", 32'(wr_cnt - wr0), 32'd0);
        chk("zero_busy_seen", 32'(busy_seen), 32'd0);

        // Oversized count clamps to full depth.
        wr0 = wr_cnt;
        do_start(70);
        chk("clamp_err", 32'(err), 32'd1);
        for (int i = 0; i < 64; i++) begin
            w = {pat_byte(i, 3), pat_byte(i, 2), pat_byte(i, 1), pat_byte(i, 0)};
            push_wr(i, w);
            for (int k = 0; k < 4; k++) send_byte(pat_byte(i, k));
        end
        byte_valid = 1'b0;
        wait_done(10);
        chk("clamp_writes", 32'(wr_cnt - wr0), 32'd64);
        chk("clamp_last_addr", 32'(last_wr_addr), 32'd63);
        chk("clamp_err_hold", 32'(err), 32'd1);
        step();

        // One word with a stalling source.
        xfer_cnt = 0;
        vpat = 7'b1011001;
        push_wr(0, 32'h1614_1310);
        do_start(1);
        chk("stall_err_cleared", 32'(err), 32'd0);
        for (int k = 0; k < 7; k++) begin
            byte_valid = vpat[k];
            byte_data  = 8'(8'h10 + k);
            step();
        end
        byte_valid = 1'b0;
        wait_done(10);
        chk("stall_xfers", 32'(xfer_cnt), 32'd4);
        step();

        // Reset in the middle of the second word.
        push_wr(0, 32'hCAFE_F00D);
        do_start(2);
        send_word(32'hCAFE_F00D);
        send_byte(8'h11);
        send_byte(8'h22);
        byte_valid = 1'b0;
        wr0   = wr_cnt;
        done0 = done_cnt;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        step();
        rst = 1'b0;
        step();
        step();
        step();
        chk("rst_no_write", 32'(wr_cnt - wr0), 32'd0);
        chk("rst_no_done", 32'(done_cnt - done0), 32'd0);
        chk("rst_queue_empty", 32'(exp_q.size()), 32'd0);
        // Fresh load after reset: bytes 0x11,0x22 must not leak into it.
        push_wr(0, 32'h4433_2255);
        wr0 = wr_cnt;
        do_start(1);
        send_word(32'h4433_2255);
        byte_valid = 1'b0;
        wait_done(10);
        chk("post_rst_writes", 32'(wr_cnt - wr0), 32'd1);
        step();

        // Start during RECV is ignored but flagged.
        push_wr(0, 32'h0403_0201);
        push_wr(1, 32'h0807_0605);
        wr0 = wr_cnt;
        do_start(2);
        send_byte(8'h01);
        send_byte(8'h02);
        byte_valid = 1'b0;
        start      = 1'b1;
        word_count = 7'd5;
        step();
        start      = 1'b0;
        chk("late_start_err", 32'(err), 32'd1);
        chk("late_start_busy", 32'(busy), 32'd1);
        send_byte(8'h03); send_byte(8'h04);
        send_word(32'h0807_0605);
        byte_valid = 1'b0;
        wait_done(10);
        chk("late_start_writes", 32'(wr_cnt - wr0), 32'd2);
        chk("late_start_last_addr", 32'(last_wr_addr), 32'd1);
        step();
        step();
        chk("late_start_no_extra", 32'(wr_cnt - wr0), 32'd2);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning the number of 32-bit instruction-memory words.
REQ-002 The block SHALL have parameter ADDR_W, default 6, meaning the word-address width (log2 DEPTH).
REQ-003 The block SHALL have port clk  input  1  the single clock, with all state updating on its rising edge.
REQ-004 The block SHALL have port rst  input  1  the reset, asynchronous and active-high.
REQ-005 The block SHALL have port start  input  1  a one-cycle request to begin a load, sampled only in IDLE.
REQ-006 The block SHALL have port word_count  input  7  the number of words to load, sampled with start.
REQ-007 The block SHALL have port byte_valid  input  1  meaning the source offers byte_data this cycle.
REQ-008 The block SHALL have port byte_data  input  8  the program byte stream, little-endian within each word.
REQ-009 The block SHALL have port byte_ready  output  1  meaning the loader accepts a byte this cycle.
REQ-010 The block SHALL have port wr_en  output  1  the instruction-memory write strobe.
REQ-011 The block SHALL have port wr_addr  output  ADDR_W  the instruction-memory word address.
REQ-012 The block SHALL have port wr_data  output  32  the instruction word to write.
REQ-013 The block SHALL have port busy  output  1  high from the accepted start until DONE; the CPU is held while it is high.
REQ-014 The block SHALL have port done  output  1  a one-cycle pulse at the end of a load.
REQ-015 The block SHALL have port err  output  1  a sticky error flag, cleared by the next accepted start.

Function
REQ-016 The FSM SHALL have the states IDLE, RECV, WRITE and DONE.
REQ-017 In IDLE, when start=1, the FSM SHALL latch the target count, clear err, and reset the address counter and byte index to 0.
REQ-018 After the start in REQ-017, the FSM SHALL go to DONE if the count is 0 and to RECV otherwise.
REQ-019 A word_count above DEPTH SHALL be clamped to DEPTH, with err=1 set in the cycle after start.
REQ-020 In RECV, byte_ready SHALL be 1 and a byte SHALL transfer only on a cycle where byte_valid=1 and byte_ready=1.
REQ-021 Byte k (k=0..3) of a word SHALL be placed in bits [8k+7:8k], and byte_valid=0 SHALL stall RECV with no state change.
REQ-022 The transfer of byte 3 SHALL move the FSM to WRITE, and byte_ready SHALL be 0 in WRITE, DONE and IDLE.
REQ-023 In WRITE, wr_en=1 SHALL be asserted for exactly one cycle, the cycle after the byte-3 transfer.
REQ-024 During that wr_en cycle, wr_addr SHALL equal the current word index and wr_data SHALL equal the assembled word.
REQ-025 From WRITE, the FSM SHALL go to DONE if the address is count-1; otherwise it SHALL increment the address and return to RECV with byte index 0.
REQ-026 The address SHALL never wrap; the last write of a DEPTH-word load SHALL be to address DEPTH-1.
REQ-027 In DONE, the FSM SHALL pulse done=1 for one cycle, drop busy in that same cycle, and return to IDLE.
REQ-028 busy SHALL be 1 in RECV and WRITE and 0 in IDLE and DONE.
REQ-029 A start in any state other than IDLE SHALL be ignored and SHALL set err=1.
REQ-030 Bytes offered while the FSM is not in RECV SHALL NOT be consumed.
REQ-031 When wr_en=0, wr_addr and wr_data SHALL hold their last values.

Reset
REQ-032 rst=1 SHALL asynchronously force the FSM to IDLE and set byte_ready, wr_en, busy, done and err to 0.
REQ-033 rst=1 SHALL also set wr_addr to 0, wr_data to 0, the byte index to 0 and the stored count to 0.
REQ-034 A reset during a load SHALL discard any partially assembled word and SHALL produce no write and no done pulse.

Structure
REQ-035 A shared package imem_pkg SHALL hold DEPTH, ADDR_W and the state enumeration (IDLE, RECV, WRITE, DONE).
REQ-036 A single sub-module, byte_assembler, SHALL hold the 2-bit byte index and the 32-bit word register, and SHALL flag the fourth byte.
REQ-037 All outputs SHALL be registered, with no combinational path from the inputs to wr_en, wr_addr or wr_data.

Verification
REQ-038 The bench SHALL check: start with word_count=2 and bytes 83,00,00,00,03,01,10,00 with valid held high -> writes (0,00000083) then (1,00100103), then done one cycle after the second wr_en.
REQ-039 The bench SHALL check: start with word_count=0 -> done in the cycle after start, with no wr_en and busy never 1.
REQ-040 The bench SHALL check: word_count=70 -> err=1, 64 writes to addresses 0..63, then done.
REQ-041 The bench SHALL check: one word with byte_valid toggling 1,0,0,1,1,0,1 -> wr_data=assembled word and exactly 4 transfers.
REQ-042 The bench SHALL check: rst pulsed after 2 bytes of word 1 -> outputs at their reset values, no write, no done, and a subsequent load behaving normally.
REQ-043 The bench SHALL check: start asserted during RECV -> ignored, err=1, and the load completes with its original count.
